// File: rtl/flappy_pkg.sv
// Shared types and helpers for the Flappy Bird vertical-motion stage.
package flappy_pkg;

  typedef enum logic [1:0] {IDLE, FLY, DEAD} bird_state_t;

  localparam int ROWS = 8;

  function automatic logic [ROWS-1:0] onehot8(logic [2:0] p);
    logic [ROWS-1:0] one;
    one = {{(ROWS-1){1'b0}}, 1'b1};
    return one << p;
  endfunction

endpackage

// File: rtl/gravity_tick.sv
// Gravity step timer: counts 0..DIV-1 while enabled and pulses tick on the last count.
module gravity_tick #(
  parameter int DIV = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

  assign tick = en & (count == LAST);

endmodule

// File: rtl/bird_position.sv
// Bird vertical position FSM: flap edge detect, gravity falls and ground/ceiling hits.
// Optional build macro CEILING_KILL_EN: a flap that would overshoot row 7 ends the game.
module bird_position
  import flappy_pkg::*;
#(
  parameter int TICK_DIV    = 25_000_000,
  parameter int FLAP_HEIGHT = 2,
  parameter int START_ROW   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flap,
  input  logic            freeze,
  output logic [ROWS-1:0] row,
  output logic            groundOut,
  output logic            playing
);

  localparam logic [2:0] START_POS = 3'(START_ROW);
  localparam logic [3:0] FLAP_INC  = 4'(FLAP_HEIGHT);

  bird_state_t state, state_next;
  logic [2:0]  pos, pos_next, flap_pos;
  logic [3:0]  flap_sum;
  logic        ground_next;
  logic        flap_q, flap_edge;
  logic        fly, cnt_clr, tick;

  assign flap_edge = flap & ~flap_q;
  assign fly       = (state == FLY);
  // bit 3 of the sum flags an overshoot past the top row
  assign flap_sum  = {1'b0, pos} + FLAP_INC;
  assign flap_pos  = flap_sum[3] ? 3'd7 : flap_sum[2:0];
  assign cnt_clr   = (state == IDLE) || (fly && flap_edge);

  gravity_tick #(.DIV(TICK_DIV)) u_gravity (
    .clock (clock),
    .reset (reset),
    .en    (fly),
    .clr   (cnt_clr),
    .tick  (tick)
  );

  always_comb begin
    state_next  = state;
    pos_next    = pos;
    ground_next = groundOut;
    case (state)
      IDLE: begin
        if (freeze)         state_next = DEAD;
        else if (flap_edge) state_next = FLY;
      end
      FLY: begin
        if (freeze) begin
          state_next = DEAD;
        end else if (flap_edge) begin
`ifdef CEILING_KILL_EN
          if (flap_sum[3]) begin
            pos_next    = 3'd7;
            ground_next = 1'b1;
            state_next  = DEAD;
          end else begin
            pos_next = flap_pos;
          end
`else
          pos_next = flap_pos;
`endif
        end else if (tick) begin
          if (pos == 3'd0) begin
            ground_next = 1'b1;
            state_next  = DEAD;
          end else begin
            pos_next = pos - 3'd1;
          end
        end
      end
      DEAD:    ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pos       <= START_POS;
      row       <= onehot8(START_POS);
      groundOut <= 1'b0;
      playing   <= 1'b0;
      flap_q    <= 1'b0;
    end else begin
      state     <= state_next;
      pos       <= pos_next;
      row       <= onehot8(pos_next);
      groundOut <= ground_next;
      playing   <= (state_next == FLY);
      flap_q    <= flap;
    end
  end

endmodule

// File: tb/tb_bird_position.sv
// Self-checking bench for bird_position: directed game scenarios plus random play vs a reference model.
module tb_bird_position;

  localparam int TICK_DIV    = 4;
  localparam int FLAP_HEIGHT = 2;
  localparam int START_ROW   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       flap  = 1'b0;
  logic       freeze = 1'b0;
  logic [7:0] row;
  logic       groundOut;
  logic       playing;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  bird_position #(
    .TICK_DIV    (TICK_DIV),
    .FLAP_HEIGHT (FLAP_HEIGHT),
    .START_ROW   (START_ROW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flap      (flap),
    .freeze    (freeze),
    .row       (row),
    .groundOut (groundOut),
    .playing   (playing)
  );

  always #5 clock = ~clock;

  // Game-level reference: st 0=waiting, 1=flying, 2=over; cnt = clocks into the current gravity period.
  typedef struct {
    int st;
    int pos;
    int cnt;
    bit ground;
    bit last_flap;
  } mdl_t;

  mdl_t m = '{st: 0, pos: START_ROW, cnt: 0, ground: 1'b0, last_flap: 1'b0};

  function automatic mdl_t mdl_next(mdl_t c, bit rst, bit f, bit frz);
    mdl_t n;
    bit pressed;
    n = c;
    if (rst) begin
      n = '{st: 0, pos: START_ROW, cnt: 0, ground: 1'b0, last_flap: 1'b0};
      return n;
    end
    pressed = f && !c.last_flap;
    n.last_flap = f;
    if (c.st == 0) begin
      if (frz) n.st = 2;
      else if (pressed) begin n.st = 1; n.cnt = 0; end
    end else if (c.st == 1) begin
      if (frz) begin
        n.st = 2;
      end else if (pressed) begin
        n.cnt = 0;
        n.pos = (c.pos + FLAP_HEIGHT > 7) ? 7 : c.pos + FLAP_HEIGHT;
`ifdef CEILING_KILL_EN
        if (c.pos + FLAP_HEIGHT > 7) begin n.ground = 1'b1; n.st = 2; end
`endif
      end else if (c.cnt == TICK_DIV - 1) begin
        n.cnt = 0;
        if (c.pos == 0) begin n.ground = 1'b1; n.st = 2; end
        else n.pos = c.pos - 1;
      end else begin
        n.cnt = c.cnt + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clock) m <= mdl_next(m, reset, flap, freeze);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_row", 32'(row), 32'(1) << m.pos);
      check("model_ground", 32'(groundOut), 32'(m.ground));
      check("model_playing", 32'(playing), 32'(m.st == 1));
      check("row_onehot", 32'($onehot(row)), 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    flap = 1'b0;
    freeze = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic lit(input string name, input logic [7:0] r, input logic g, input logic p);
    check({name, "_row"}, 32'(row), 32'(r));
    check({name, "_ground"}, 32'(groundOut), 32'(g));
    check({name, "_playing"}, 32'(playing), 32'(p));
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;

    // Idle after reset
    step(20);
    lit("idle", 8'h10, 1'b0, 1'b0);

    // Start, then free fall to the ground
    flap = 1'b1; step(1);
    lit("start", 8'h10, 1'b0, 1'b1);
    flap = 1'b0;
    step(4); lit("fall3", 8'h08, 1'b0, 1'b1);
    step(4); lit("fall2", 8'h04, 1'b0, 1'b1);
    step(4); lit("fall1", 8'h02, 1'b0, 1'b1);
    step(4); lit("fall0", 8'h01, 1'b0, 1'b1);
    step(4); lit("ground", 8'h01, 1'b1, 1'b0);
    flap = 1'b1; step(5); flap = 1'b0; step(5);
    lit("ground_hold", 8'h01, 1'b1, 1'b0);

    // Climb to the ceiling
    do_reset();
    flap = 1'b1; step(1); flap = 1'b0; step(1);
    flap = 1'b1; step(1);
    lit("climb6", 8'h40, 1'b0, 1'b1);
    flap = 1'b0; step(1); flap = 1'b1; step(1);
`ifdef CEILING_KILL_EN
    lit("ceil_kill", 8'h80, 1'b1, 1'b0);
`else
    lit("ceil_sat", 8'h80, 1'b0, 1'b1);
`endif
    flap = 1'b0; step(1); flap = 1'b1; step(1);
`ifdef CEILING_KILL_EN
    lit("ceil_again", 8'h80, 1'b1, 1'b0);
`else
    lit("ceil_again", 8'h80, 1'b0, 1'b1);
`endif
    flap = 1'b0;

    // Flap on the same clock as a tick at row 3
    do_reset();
    flap = 1'b1; step(1); flap = 1'b0;
    step(4); lit("pre_tick", 8'h08, 1'b0, 1'b1);
    step(3);
    flap = 1'b1; step(1);
    lit("flap_on_tick", 8'h20, 1'b0, 1'b1);
    flap = 1'b0;
    step(3); lit("no_fall_yet", 8'h20, 1'b0, 1'b1);
    step(1); lit("next_fall", 8'h10, 1'b0, 1'b1);

    // Held flap jumps once; release and re-press jumps again
    flap = 1'b1; step(1);
    lit("hold_jump", 8'h40, 1'b0, 1'b1);
    step(9);
    lit("hold_end", 8'h10, 1'b0, 1'b1);
    flap = 1'b0; step(1);
    flap = 1'b1; step(1);
    lit("repress", 8'h40, 1'b0, 1'b1);
    flap = 1'b0;

    // Freeze at row 5, then reset
    do_reset();
    flap = 1'b1; step(1); flap = 1'b0; step(1);
    flap = 1'b1; step(1); flap = 1'b0;
    step(4); lit("pos5", 8'h20, 1'b0, 1'b1);
    freeze = 1'b1; step(1);
    lit("frozen", 8'h20, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      flap = 1'($urandom_range(0, 1));
      step(1);
    end
    lit("frozen_hold", 8'h20, 1'b0, 1'b0);
    freeze = 1'b0;
    flap = 1'b0;
    reset = 1'b1; step(1); reset = 1'b0;
    lit("after_reset", 8'h10, 1'b0, 1'b0);
    flap = 1'b1; step(1);
    lit("restart", 8'h10, 1'b0, 1'b1);
    flap = 1'b0;

    // Random play
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      flap   = ($urandom_range(0, 5) == 0);
      freeze = ($urandom_range(0, 299) == 0);
      reset  = ($urandom_range(0, 149) == 0);
      step(1);
    end
    reset = 1'b0;
    freeze = 1'b0;
    flap = 1'b0;
    step(2);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
